memory_master: RTL and testbench

//  Bus initiator for the 256x16 memory's start/ready/rwn handshake. Arbitrates a read-only

---
 rtl/mem_bus_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 48 ++++
 rtl/memory_master.sv | 136 +++++++++++++
 tb/tb_memory_master.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types for the memory bus initiator: FSM states, port grant encoding,
// and default bus widths.
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_arbiter.sv
// Fixed-priority fetch/data arbiter with a starvation counter that forces a
// fetch grant after STARVE_LIMIT consecutive data grants made while fetch waited.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic i_req,
  input  logic d_req,
  output gnt_t pick,
  output gnt_t grant,
  output logic grant_vld
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;
  logic          force_i;

  assign force_i = i_req && (starve_cnt >= CW'(STARVE_LIMIT));

  // pick is combinational so the master can load the bus on the granting edge
  always_comb begin
    pick = GNT_I;
    if (d_req && !force_i) pick = GNT_D;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      grant      <= GNT_I;
      grant_vld  <= 1'b0;
    end else begin
      grant_vld <= arb_en;
      if (arb_en) begin
        grant <= pick;
        if (pick == GNT_I)
          starve_cnt <= '0;
        else if (i_req)
          starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_master.sv
// Bus initiator for the start/ready/rwn memory handshake: arbitrates fetch and
// data ports, runs one transaction at a time and watchdogs the completion.
module memory_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int TIMEOUT      = 15,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_rwn,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              busy,
  output logic              mem_start,
  output logic              mem_rwn,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [WCW-1:0]    wait_cnt;
  logic              arb_en;
  gnt_t              pick;
  gnt_t              grant;
  logic              grant_vld;
  logic              wait_tmo;
  logic              wait_end;
  logic              load_rd;
  logic [DATA_W-1:0] rd_val;

  assign arb_en   = (state == ST_IDLE) && mem_ready && (d_req || i_req);
  assign wait_tmo = !mem_ready && (wait_cnt == WCW'(TIMEOUT - 1));
  assign wait_end = mem_ready || wait_tmo;
  // mem_rwn still holds the latched direction of the transaction in flight
  assign load_rd  = wait_tmo || mem_rwn;
  assign rd_val   = wait_tmo ? '0 : mem_rdata;

  mem_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .arb_en   (arb_en),
    .i_req    (i_req),
    .d_req    (d_req),
    .pick     (pick),
    .grant    (grant),
    .grant_vld(grant_vld)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      i_ack       <= 1'b0;
      i_rdata     <= '0;
      d_ack       <= 1'b0;
      d_rdata     <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      mem_start   <= 1'b0;
      mem_rwn     <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_en) begin
            mem_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_ISSUE;
            if (pick == GNT_D) begin
              mem_address <= d_addr;
              mem_rwn     <= d_rwn;
              mem_wdata   <= d_wdata;
            end else begin
              mem_address <= i_addr;
              mem_rwn     <= 1'b1;
            end
          end
        end
        // ready is still high from idle here, so it is not a completion
        ST_ISSUE: begin
          mem_start <= 1'b0;
          wait_cnt  <= '0;
          if (grant_vld) begin
            state <= ST_WAIT;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (wait_end) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            err   <= wait_tmo;
            if (grant == GNT_D) begin
              d_ack <= 1'b1;
              if (load_rd) d_rdata <= rd_val;
            end else begin
              i_ack <= 1'b1;
              if (load_rd) i_rdata <= rd_val;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          mem_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_master.sv
// Bench for memory_master: behavioural 256x16 memory, queued requesters and a
// transaction-level reference model compared against the DUT every cycle.
module tb_memory_master;

  localparam int TMO = 15;
  localparam int SL  = 4;

  typedef struct packed {
    logic        rwn;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } dreq_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [7:0]  i_addr = '0;
  logic        i_ack;
  logic [15:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_rwn = 1'b1;
  logic [7:0]  d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        err, busy, mem_start, mem_rwn, mem_ready;
  logic [7:0]  mem_address;
  logic [15:0] mem_wdata, mem_rdata;

  memory_master #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(TMO), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_rwn(d_rwn), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err), .busy(busy),
    .mem_start(mem_start), .mem_rwn(mem_rwn), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- memory (hang stalls completion for the watchdog test)
  bit          hang = 1'b0;
  logic [15:0] ram [256];
  logic        mb, mh;
  logic [1:0]  mc;
  logic [7:0]  ma;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < 256; a++) ram[a] <= 16'h0;
      ram[2] <= 16'h0005;
      ram[4] <= 16'h000B;
      mem_ready <= 1'b1;
      mem_rdata <= '0;
      mb <= 1'b0; mh <= 1'b0; mc <= '0; ma <= '0;
    end else if (mb) begin
      if (mc != 0) mc <= mc - 1'b1;
      else if (!(mh && hang)) begin
        mem_ready <= 1'b1;
        mem_rdata <= ram[ma];
        mb <= 1'b0;
      end
    end else if (mem_start && mem_ready) begin
      mem_ready <= 1'b0;
      mb <= 1'b1; mc <= mem_address[1:0]; ma <= mem_address; mh <= hang;
      if (!mem_rwn) ram[mem_address] <= mem_wdata;
    end
  end

  // ---------------- requesters, reference model, per-cycle compare
  dreq_t       dq[$];
  logic [7:0]  iq[$];
  bit          ack_log[$];
  logic [15:0] shadow [256];
  logic [15:0] e_i_rdata, e_d_rdata;
  bit          t_act = 1'b0, t_d, t_rd, t_tmo;
  logic [7:0]  t_addr;
  logic [15:0] t_wdata;
  int          t_g, t_ack, starve;
  int          i_set_cyc, d_set_cyc, last_i_ack_cyc, last_d_ack_cyc, start_cnt = 0;
  logic [15:0] last_i_rdata, last_d_rdata;
  logic        last_err;

  always @(negedge clk) begin
    bit    e_iack, e_dack, e_err, e_busy, e_start, e_dchk;
    dreq_t r;
    if (reset) begin
      t_act = 1'b0; starve = 0; e_i_rdata = '0; e_d_rdata = '0;
      for (int a = 0; a < 256; a++) shadow[a] = 16'h0;
      shadow[2] = 16'h0005;
      shadow[4] = 16'h000B;
      i_req = 1'b0; d_req = 1'b0;
    end else begin
      e_iack = 0; e_dack = 0; e_err = 0; e_busy = 0; e_start = 0; e_dchk = 0;
      if (t_act) begin
        e_start = (cyc == t_g);
        e_busy  = (cyc >= t_g) && (cyc < t_ack);
        if (cyc == t_ack) begin
          e_err = t_tmo;
          if (t_d) begin
            e_dack = 1; e_dchk = t_rd || t_tmo;
            if (t_tmo) e_d_rdata = '0; else if (t_rd) e_d_rdata = shadow[t_addr];
          end else begin
            e_iack = 1;
            e_i_rdata = t_tmo ? 16'h0 : shadow[t_addr];
          end
          t_act = 1'b0;
        end
      end
      chk("i_ack", i_ack, e_iack);
      chk("d_ack", d_ack, e_dack);
      chk("err", err, e_err);
      chk("busy", busy, e_busy);
      chk("mem_start", mem_start, e_start);
      chk("i_rdata", i_rdata, e_i_rdata);
      if (e_dchk) chk("d_rdata", d_rdata, e_d_rdata);
      if (e_start) begin
        chk("mem_address", mem_address, t_addr);
        chk("mem_rwn", mem_rwn, t_rd);
        if (!t_rd) chk("mem_wdata", mem_wdata, t_wdata);
      end
      if (mem_start) begin
        start_cnt++;
        chk("start_while_not_ready", mem_ready, 1'b1);
      end
      if (i_ack) begin last_i_ack_cyc = cyc; last_i_rdata = i_rdata; last_err = err; ack_log.push_back(1'b0); end
      if (d_ack) begin last_d_ack_cyc = cyc; last_d_rdata = d_rdata; last_err = err; ack_log.push_back(1'b1); end

      // requesters drop on ack and may immediately present the next request
      if (i_req && i_ack) i_req = 1'b0;
      if (d_req && d_ack) d_req = 1'b0;
      if (!i_req && iq.size() > 0) begin
        i_addr = iq.pop_front(); i_req = 1'b1; i_set_cyc = cyc;
      end
      if (!d_req && dq.size() > 0) begin
        r = dq.pop_front();
        d_rwn = r.rwn; d_addr = r.addr; d_wdata = r.wdata; d_req = 1'b1; d_set_cyc = cyc;
      end

      // predict a grant on the coming edge
      if (!t_act && mem_ready && (i_req || d_req)) begin
        t_d = d_req && !(i_req && starve >= SL);
        if (t_d) begin
          t_rd = d_rwn; t_addr = d_addr; t_wdata = d_wdata;
          if (i_req) starve++;
        end else begin
          t_rd = 1'b1; t_addr = i_addr; t_wdata = '0; starve = 0;
        end
        if (!t_rd) shadow[t_addr] = t_wdata;
        t_tmo = hang;
        t_g   = cyc + 1;
        t_ack = t_tmo ? t_g + TMO + 1 : t_g + int'(t_addr[1:0]) + 3;
        t_act = 1'b1;
      end
    end
  end

  task automatic drain(input int maxc);
    int n = 0;
    while ((iq.size() > 0 || dq.size() > 0 || i_req || d_req || t_act) && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= maxc) begin
      checks++; errors++;
      $display("FAIL drain: still pending after %0d cycles, required idle", maxc);
    end
  endtask

  initial begin
    int nd, sc0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // 1: fetch read of 0x02
    @(posedge clk); #1 iq.push_back(8'h02);
    drain(50);
    chk("t1_latency", last_i_ack_cyc - i_set_cyc - 1, 5);
    chk("t1_rdata", last_i_rdata, 16'h0005);
    chk("t1_err", last_err, 0);

    // 2: write then read 0x05
    dq.push_back('{rwn: 1'b0, addr: 8'h05, wdata: 16'h1234});
    drain(50);
    chk("t2_wlatency", last_d_ack_cyc - d_set_cyc - 1, 4);
    dq.push_back('{rwn: 1'b1, addr: 8'h05, wdata: 16'h0});
    drain(50);
    chk("t2_rdata", last_d_rdata, 16'h1234);

    // 3: data held continuously against a pending fetch
    ack_log.delete();
    for (int j = 0; j < 5; j++) dq.push_back('{rwn: 1'b1, addr: 8'($urandom_range(0, 255)), wdata: 16'h0});
    iq.push_back(8'h10);
    drain(200);
    nd = 0;
    for (int j = 0; j < 4 && j < ack_log.size(); j++) nd += int'(ack_log[j]);
    chk("t3_acks", ack_log.size(), 6);
    chk("t3_first4_data", nd, 4);
    chk("t3_fifth_fetch", (ack_log.size() > 4) ? ack_log[4] : 1'b1, 1'b0);

    // 4: watchdog timeout, then no issue until memory is ready again
    hang = 1'b1;
    dq.push_back('{rwn: 1'b1, addr: 8'h03, wdata: 16'h0});
    drain(60);
    chk("t4_err", last_err, 1);
    chk("t4_latency", last_d_ack_cyc - d_set_cyc - 1, 16);
    chk("t4_rdata", last_d_rdata, 16'h0);
    sc0 = start_cnt;
    iq.push_back(8'h04);
    repeat (5) @(posedge clk);
    #1 chk("t4_hold_no_start", start_cnt - sc0, 0);
    hang = 1'b0;
    drain(50);
    chk("t4_after_rdata", last_i_rdata, 16'h000B);

    // 5: reset during WAIT
    dq.push_back('{rwn: 1'b1, addr: 8'h07, wdata: 16'h0});
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_ctl", {i_ack, d_ack, err, busy, mem_start, mem_rwn}, 0);
    chk("t5_rst_bus", {mem_address, mem_wdata}, 0);
    chk("t5_rst_rdata", {i_rdata, d_rdata}, 0);
    dq.delete(); iq.delete();
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #1 dq.push_back('{rwn: 1'b1, addr: 8'h04, wdata: 16'h0});
    drain(50);
    chk("t5_rdata", last_d_rdata, 16'h000B);

    // 6: back-to-back data requests
    sc0 = start_cnt;
    dq.push_back('{rwn: 1'b1, addr: 8'h02, wdata: 16'h0});
    dq.push_back('{rwn: 1'b0, addr: 8'h21, wdata: 16'hBEEF});
    dq.push_back('{rwn: 1'b1, addr: 8'h21, wdata: 16'h0});
    drain(80);
    chk("t6_starts", start_cnt - sc0, 3);
    chk("t6_rdata", last_d_rdata, 16'hBEEF);

    // random mix on both ports
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0 && dq.size() < 3)
        dq.push_back('{rwn: 1'($urandom_range(0, 1)), addr: 8'($urandom_range(0, 15)),
                       wdata: 16'($urandom)});
      if ($urandom_range(0, 4) == 0 && iq.size() < 3)
        iq.push_back(8'($urandom_range(0, 15)));
    end
    drain(2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
